// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and constants for the direct-mapped cache and
//               its backing memory: FSM state encoding, block geometry and
//               the cache address-field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Backing-memory FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESPOND = 2'd3
    } mem_state_t;

    // Block geometry: a block is four bytes returned together on a line fill
    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 8;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

    // Cache address split: {tag, index, offset} over a 10-bit byte address
    localparam int CACHE_ADDR_W    = 10;
    localparam int OFFSET_W        = 2;
    localparam int INDEX_W         = 4;
    localparam int TAG_W           = CACHE_ADDR_W - INDEX_W - OFFSET_W;

    // Width of the latency down-counter (latencies 1..15)
    localparam int CNT_W           = 4;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/latency_counter.sv
`default_nettype none
// ============================================================================
// Module      : latency_counter
// Description : Loadable down-counter used to time memory accesses. It
//               saturates at zero and flags done while the count is zero.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset (count -> 0)
//               load_i     - load load_val_i (takes priority over dec_i)
//               load_val_i - value to load
//               dec_i      - decrement by one when non-zero
//               done_o     - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule : latency_counter
`default_nettype wire

// File: rtl/cache_backing_mem.sv
`default_nettype none
// ============================================================================
// Module      : cache_backing_mem
// Description : Byte-addressed backing memory for the direct-mapped cache
//               with a fixed-latency request/ready handshake. Reads return a
//               whole 4-byte block; writes store one byte (write-through).
// Ports       : clk                    - clock, rising edge
//               rst                    - asynchronous active-low reset
//               cache_read_req_to_mem  - block read request (sampled in IDLE)
//               cache_write_req_to_mem - byte write request (sampled in IDLE)
//               AddressBus             - byte address
//               dInputBus              - write byte
//               dOutputBus             - block read data, byte k at [8k+7:8k]
//               memoryRR               - one-cycle read-ready pulse
//               memoryWR               - one-cycle write-ready pulse
//               mem_busy               - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module cache_backing_mem
    import cache_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cache_read_req_to_mem,
    input  logic               cache_write_req_to_mem,
    input  logic [ADDR_W-1:0]  AddressBus,
    input  logic [WORD_W-1:0]  dInputBus,
    output logic [BLOCK_W-1:0] dOutputBus,
    output logic               memoryRR,
    output logic               memoryWR,
    output logic               mem_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    mem_state_t        state_q;
    mem_state_t        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] data_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_done;
    logic              rd_done;
    logic              wr_done;

    logic [WORD_W-1:0]  mem_q [DEPTH];
    logic [BLOCK_W-1:0] dout_q;
    logic               rr_q;
    logic               wr_q;

    // ------------------------------------------------------------------
    // Latency timer
    // ------------------------------------------------------------------
    latency_counter #(
        .CNT_W (CNT_W)
    ) u_latency_counter (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    // ------------------------------------------------------------------
    // FSM next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        rd_done      = 1'b0;
        wr_done      = 1'b0;

        case (state_q)
            IDLE: begin
                // Read wins a collision; the write is dropped, not queued
                if (cache_read_req_to_mem) begin
                    addr_d       = {AddressBus[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(READ_LATENCY - 1);
                    state_d      = RD_WAIT;
                end else if (cache_write_req_to_mem) begin
                    addr_d       = AddressBus;
                    data_d       = dInputBus;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(WRITE_LATENCY - 1);
                    state_d      = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_done) begin
                    rd_done = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WR_WAIT: begin
                if (cnt_done) begin
                    wr_done = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage array: reset loads mem[a] = a[7:0]
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WORD_W'(i);
            end
        end else if (wr_done) begin
            mem_q[addr_q] <= data_q;
        end
    end

    // ------------------------------------------------------------------
    // Completion outputs, registered on the edge that enters RESPOND
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            rr_q   <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            rr_q <= rd_done;
            wr_q <= wr_done;
            if (rd_done) begin
                for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                    dout_q[k*WORD_W +: WORD_W] <=
                        mem_q[{addr_q[ADDR_W-1:OFFSET_W], OFFSET_W'(k)}];
                end
            end
        end
    end

    assign dOutputBus = dout_q;
    assign memoryRR   = rr_q;
    assign memoryWR   = wr_q;
    assign mem_busy   = (state_q != IDLE);

endmodule : cache_backing_mem
`default_nettype wire

// File: tb/tb_cache_backing_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_backing_mem
// Description : Self-checking bench for cache_backing_mem. A byte-array
//               reference model tracks memory contents; each scenario task
//               drives the handshake and compares against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_backing_mem;

    localparam int RL = 4;
    localparam int WL = 2;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [7:0]  din;
    logic [31:0] dout;
    logic        rr;
    logic        wrr;
    logic        busy;

    int vectors;
    int miscompares;

    logic [7:0] ref_mem [1024];

    cache_backing_mem #(
        .ADDR_W        (10),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cache_read_req_to_mem  (rd),
        .cache_write_req_to_mem (wr),
        .AddressBus             (addr),
        .dInputBus              (din),
        .dOutputBus             (dout),
        .memoryRR               (rr),
        .memoryWR               (wrr),
        .mem_busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i);
    endtask

    function automatic logic [31:0] model_block(input logic [9:0] a);
        int base;
        base = int'(a) & ~3;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    // ---------------- drivers ----------------
    // Issue one read; report latency (edges after acceptance), data, whether
    // memoryRR was still high one cycle later, and mem_busy after acceptance.
    task automatic read_op(input logic [9:0] a, output logic [31:0] d,
                           output int lat, output logic after, output logic busy_acc);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        @(posedge clk); #1;
        rd       = 1'b0;
        busy_acc = busy;
        lat      = -1;
        d        = '0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (rr) begin
                lat = n;
                d   = dout;
                break;
            end
        end
        @(posedge clk); #1;
        after = rr;
    endtask

    task automatic write_op(input logic [9:0] a, input logic [7:0] v,
                            output int lat, output logic after);
        @(negedge clk);
        addr = a;
        din  = v;
        wr   = 1'b1;
        @(posedge clk); #1;
        wr  = 1'b0;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (wrr) begin
                lat = n;
                break;
            end
        end
        @(posedge clk); #1;
        after = wrr;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dout !== 32'h0) begin miscompares++; $display("FAIL reset_dout got=%h exp=%h", dout, 32'h0); end
        vectors++;
        if (rr !== 1'b0) begin miscompares++; $display("FAIL reset_rr got=%b exp=0", rr); end
        vectors++;
        if (wrr !== 1'b0) begin miscompares++; $display("FAIL reset_wr got=%b exp=0", wrr); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read_basic();
        logic [31:0] d; int lat; logic after; logic ba;
        read_op(10'h00D, d, lat, after, ba);
        vectors++;
        if (lat != RL) begin miscompares++; $display("FAIL rd_latency got=%0d exp=%0d", lat, RL); end
        vectors++;
        if (d !== 32'h0F0E0D0C) begin miscompares++; $display("FAIL rd_data got=%h exp=%h", d, 32'h0F0E0D0C); end
        vectors++;
        if (after !== 1'b0) begin miscompares++; $display("FAIL rd_pulse_width got=%b exp=0", after); end
        vectors++;
        if (ba !== 1'b1) begin miscompares++; $display("FAIL rd_busy got=%b exp=1", ba); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_write_basic();
        logic [31:0] d; int lat; logic after; logic ba;
        write_op(10'h105, 8'hAB, lat, after);
        ref_mem[10'h105] = 8'hAB;
        vectors++;
        if (lat != WL) begin miscompares++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WL); end
        vectors++;
        if (after !== 1'b0) begin miscompares++; $display("FAIL wr_pulse_width got=%b exp=0", after); end
        read_op(10'h104, d, lat, after, ba);
        vectors++;
        if (d !== 32'h0706AB04) begin miscompares++; $display("FAIL wr_readback got=%h exp=%h", d, 32'h0706AB04); end
    endtask

    task automatic test_collision();
        logic [9:0] a; logic [7:0] v; logic [31:0] d; int lat; logic after; logic ba;
        int rr_cnt; int wr_cnt;
        a = 10'($urandom_range(0, 1023));
        v = ~ref_mem[a];
        @(negedge clk);
        addr = a; din = v; rd = 1'b1; wr = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        rr_cnt = 0; wr_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (rr)  rr_cnt++;
            if (wrr) wr_cnt++;
        end
        vectors++;
        if (rr_cnt != 1) begin miscompares++; $display("FAIL coll_rr_count got=%0d exp=1", rr_cnt); end
        vectors++;
        if (wr_cnt != 0) begin miscompares++; $display("FAIL coll_wr_count got=%0d exp=0", wr_cnt); end
        read_op(a, d, lat, after, ba);
        vectors++;
        if (d !== model_block(a)) begin miscompares++; $display("FAIL coll_unchanged got=%h exp=%h", d, model_block(a)); end
    endtask

    task automatic test_busy_ignore();
        logic [9:0] a1; logic [9:0] a2; logic [31:0] d; int cnt;
        a1 = 10'h248;
        a2 = 10'h0F1;
        @(negedge clk);
        addr = a1; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        addr = a2; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        cnt = 0; d = '0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (rr) begin cnt++; d = dout; end
        end
        vectors++;
        if (cnt != 1) begin miscompares++; $display("FAIL busy_ignore_count got=%0d exp=1", cnt); end
        vectors++;
        if (d !== model_block(a1)) begin miscompares++; $display("FAIL busy_ignore_data got=%h exp=%h", d, model_block(a1)); end
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] d; int lat; logic after; logic ba; int cnt;
        @(negedge clk);
        addr = 10'h3FF; din = 8'h55; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (dout !== 32'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs got dout=%h busy=%b exp dout=0 busy=0", dout, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (wrr) cnt++;
        end
        vectors++;
        if (cnt != 0) begin miscompares++; $display("FAIL midrst_wr_pulse got=%0d exp=0", cnt); end
        read_op(10'h3FC, d, lat, after, ba);
        vectors++;
        if (d !== 32'hFFFEFDFC) begin miscompares++; $display("FAIL midrst_readback got=%h exp=%h", d, 32'hFFFEFDFC); end
    endtask

    task automatic test_back_to_back();
        int c1; int c2; logic [31:0] d1; logic [31:0] d2; logic hold_ok;
        c1 = -1; c2 = -1; d1 = '0; d2 = '0; hold_ok = 1'b1;
        @(negedge clk);
        addr = 10'h3FC; rd = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) addr = 10'h000;
            if (rr) begin
                if (c1 < 0) begin
                    c1 = cyc; d1 = dout;
                end else begin
                    c2 = cyc; d2 = dout; rd = 1'b0;
                    break;
                end
            end else if (c1 >= 0 && dout !== d1) begin
                hold_ok = 1'b0;
            end
        end
        rd = 1'b0;
        vectors++;
        if (d1 !== model_block(10'h3FC)) begin miscompares++; $display("FAIL b2b_first got=%h exp=%h", d1, model_block(10'h3FC)); end
        vectors++;
        if (d2 !== model_block(10'h000)) begin miscompares++; $display("FAIL b2b_second got=%h exp=%h", d2, model_block(10'h000)); end
        // READ_LATENCY+1 cycles without a pulse lie between the two pulses
        vectors++;
        if (c1 < 0 || c2 < 0 || (c2 - c1 - 1) != RL + 1) begin
            miscompares++;
            $display("FAIL b2b_gap got=%0d exp=%0d", c2 - c1 - 1, RL + 1);
        end
        vectors++;
        if (hold_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_hold got=%b exp=1", hold_ok); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [9:0] a; logic [7:0] v; logic [31:0] d; int lat; logic after; logic ba;
        for (int i = 0; i < 40; i++) begin
            a = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) begin
                v = 8'($urandom_range(0, 255));
                write_op(a, v, lat, after);
                ref_mem[a] = v;
                vectors++;
                if (lat != WL || after !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_wr[%0d] got lat=%0d after=%b exp lat=%0d after=0", i, lat, after, WL);
                end
            end else begin
                read_op(a, d, lat, after, ba);
                vectors++;
                if (d !== model_block(a) || lat != RL) begin
                    miscompares++;
                    $display("FAIL rand_rd[%0d] addr=%h got=%h lat=%0d exp=%h lat=%0d", i, a, d, lat, model_block(a), RL);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_read_basic();
        test_write_basic();
        test_collision();
        test_busy_ignore();
        test_reset_midwrite();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cache_backing_mem
`default_nettype wire
